// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter
// Consumes the 100 Hz tick and accumulates centiseconds, seconds, minutes
// and hours under RUN/STOP/CLEAR control. All outputs are registered so the
// display formatter can sample them directly.
module stopwatch_time_counter #(
  parameter int MSEC_MAX = 100,
  parameter int SEC_MAX  = 60,
  parameter int MIN_MAX  = 60,
  parameter int HOUR_MAX = 24,
  localparam int MSEC_W  = $clog2(MSEC_MAX),
  localparam int SEC_W   = $clog2(SEC_MAX),
  localparam int MIN_W   = $clog2(MIN_MAX),
  localparam int HOUR_W  = $clog2(HOUR_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick_100hz,
  input  logic              i_run_stop,
  input  logic              i_clear,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_running
);

  localparam logic [MSEC_W-1:0] MSEC_LAST = MSEC_W'(MSEC_MAX - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX - 1);
  localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_MAX - 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t state;

  logic msec_wrap;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap;

  // Carry chain: each stage wraps only when it and every lower stage are at their last value.
  always_comb begin
    msec_wrap = (o_msec == MSEC_LAST);
    sec_wrap  = msec_wrap && (o_sec == SEC_LAST);
    min_wrap  = sec_wrap  && (o_min == MIN_LAST);
    hour_wrap = min_wrap  && (o_hour == HOUR_LAST);
  end

  // Control FSM plus count registers; a tick is counted on the current state, not the requested one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_STOP;
      o_running <= 1'b0;
      o_msec    <= '0;
      o_sec     <= '0;
      o_min     <= '0;
      o_hour    <= '0;
    end else begin
      case (state)
        ST_STOP: begin
          // Run/stop wins over clear when both arrive together.
          if (i_run_stop) begin
            state     <= ST_RUN;
            o_running <= 1'b1;
          end else if (i_clear) begin
            state     <= ST_CLEAR;
          end
        end
        ST_RUN: begin
          if (i_tick_100hz) begin
            o_msec <= msec_wrap ? '0 : o_msec + 1'b1;
            if (msec_wrap) o_sec  <= sec_wrap  ? '0 : o_sec + 1'b1;
            if (sec_wrap)  o_min  <= min_wrap  ? '0 : o_min + 1'b1;
            if (min_wrap)  o_hour <= hour_wrap ? '0 : o_hour + 1'b1;
          end
          if (i_run_stop) begin
            state     <= ST_STOP;
            o_running <= 1'b0;
          end
        end
        ST_CLEAR: begin
          o_msec    <= '0;
          o_sec     <= '0;
          o_min     <= '0;
          o_hour    <= '0;
          o_running <= 1'b0;
          state     <= ST_STOP;
        end
        default: begin
          state     <= ST_STOP;
          o_running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter: a full-size instance for the
// normal cascade and control behaviour, and a reduced-modulus instance so the
// complete wrap-around fits in a short run.
module tb_stopwatch_time_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_tick_100hz = 1'b0;
  logic i_run_stop = 1'b0;
  logic i_clear = 1'b0;

  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_running;

  logic [1:0] s_msec;
  logic [1:0] s_sec;
  logic [1:0] s_min;
  logic [0:0] s_hour;
  logic       s_running;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stopwatch_time_counter dut (
    .clk          (clk),
    .rst          (rst),
    .i_tick_100hz (i_tick_100hz),
    .i_run_stop   (i_run_stop),
    .i_clear      (i_clear),
    .o_msec       (o_msec),
    .o_sec        (o_sec),
    .o_min        (o_min),
    .o_hour       (o_hour),
    .o_running    (o_running)
  );

  // Moduli 4/3/3/2: full wrap after 72 ticks.
  stopwatch_time_counter #(
    .MSEC_MAX (4),
    .SEC_MAX  (3),
    .MIN_MAX  (3),
    .HOUR_MAX (2)
  ) dut_small (
    .clk          (clk),
    .rst          (rst),
    .i_tick_100hz (i_tick_100hz),
    .i_run_stop   (i_run_stop),
    .i_clear      (i_clear),
    .o_msec       (s_msec),
    .o_sec        (s_sec),
    .o_min        (s_min),
    .o_hour       (s_hour),
    .o_running    (s_running)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs applied; outputs are readable on return.
  task automatic cycle(input logic tick, input logic rs, input logic clr);
    i_tick_100hz = tick;
    i_run_stop   = rs;
    i_clear      = clr;
    @(posedge clk);
    #1;
    i_tick_100hz = 1'b0;
    i_run_stop   = 1'b0;
    i_clear      = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    // Reset held 3 cycles with run/stop pulsed: reset dominates.
    rst = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    check("rst_msec", o_msec, 0);
    check("rst_sec", o_sec, 0);
    check("rst_min", o_min, 0);
    check("rst_hour", o_hour, 0);
    check("rst_running", o_running, 0);
    cycle(1'b1, 1'b0, 1'b0);
    check("rst_stop_holds", o_msec, 0);

    // Run, 150 ticks, stop, 20 more ticks ignored.
    cycle(1'b0, 1'b1, 1'b0);
    check("run_running", o_running, 1);
    ticks(150);
    check("run150_sec", o_sec, 1);
    check("run150_msec", o_msec, 50);
    cycle(1'b0, 1'b1, 1'b0);
    check("stop_running", o_running, 0);
    ticks(20);
    check("stop_hold_sec", o_sec, 1);
    check("stop_hold_msec", o_msec, 50);

    // 00:00:59.99 -> 00:01:00.00
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    ticks(5999);
    check("pre_min", o_min, 0);
    check("pre_sec", o_sec, 59);
    check("pre_msec", o_msec, 99);
    ticks(1);
    check("carry_min", o_min, 1);
    check("carry_sec", o_sec, 0);
    check("carry_msec", o_msec, 0);

    // Full wrap on reduced-modulus instance.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    check("small_running", s_running, 1);
    ticks(71);
    check("small_last_hour", s_hour, 1);
    check("small_last_min", s_min, 2);
    check("small_last_sec", s_sec, 2);
    check("small_last_msec", s_msec, 3);
    ticks(1);
    check("small_wrap_hour", s_hour, 0);
    check("small_wrap_min", s_min, 0);
    check("small_wrap_sec", s_sec, 0);
    check("small_wrap_msec", s_msec, 0);

    // Tick + run/stop coincidence in RUN and in STOP.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    ticks(5);
    check("coin_pre", o_msec, 5);
    cycle(1'b1, 1'b1, 1'b0);
    check("coin_run_msec", o_msec, 6);
    check("coin_run_running", o_running, 0);
    cycle(1'b1, 1'b1, 1'b0);
    check("coin_stop_msec", o_msec, 6);
    check("coin_stop_running", o_running, 1);
    ticks(1);
    check("coin_after_msec", o_msec, 7);

    // Clear ignored in RUN; clear in STOP; clear/run together.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    ticks(37);
    check("clr_pre", o_msec, 37);
    cycle(1'b0, 1'b0, 1'b1);
    check("clr_run_ignored", o_msec, 37);
    check("clr_run_running", o_running, 1);
    ticks(1);
    check("clr_run_continue", o_msec, 38);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("clr_n1_msec", o_msec, 38);
    cycle(1'b1, 1'b1, 1'b0);
    check("clr_n2_msec", o_msec, 0);
    check("clr_n2_running", o_running, 0);
    ticks(3);
    check("clr_stop_after", o_msec, 0);
    cycle(1'b0, 1'b1, 1'b0);
    ticks(4);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    check("both_running", o_running, 1);
    cycle(1'b0, 1'b0, 1'b0);
    check("both_not_cleared", o_msec, 4);
    ticks(1);
    check("both_counting", o_msec, 5);

    // Reset mid-RUN at 00:02:13.45.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    ticks(13345);
    check("mid_min", o_min, 2);
    check("mid_sec", o_sec, 13);
    check("mid_msec", o_msec, 45);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    check("midrst_min", o_min, 0);
    check("midrst_sec", o_sec, 0);
    check("midrst_msec", o_msec, 0);
    check("midrst_running", o_running, 0);
    ticks(10);
    check("midrst_hold", o_msec, 0);
    cycle(1'b0, 1'b1, 1'b0);
    ticks(1);
    check("midrst_restart", o_msec, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_counter.md
# stopwatch_time_counter

Tick-consuming time counter for the stopwatch path. Accepts the single-cycle 100 Hz tick from the tick generator and accumulates centiseconds, seconds, minutes and hours under run/stop/clear control. Sits between the tick generator and the display formatter/FND controller, which sample its registered count outputs.

## Interface

Parameters:
- MSEC_MAX, 100, centisecond modulus (count 0..MSEC_MAX-1)
- SEC_MAX, 60, second modulus
- MIN_MAX, 60, minute modulus
- HOUR_MAX, 24, hour modulus

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-low reset: sampled on rising clk, active when 0
- i_tick_100hz  in  1  one-clk-wide pulse from the tick generator, every 1,000,000 clk
- i_run_stop  in  1  one-clk pulse from debounced button; toggles RUN/STOP
- i_clear  in  1  one-clk pulse from debounced button; zeroes counts while stopped
- o_msec  out  7  centiseconds 0..99
- o_sec  out  6  seconds 0..59
- o_min  out  6  minutes 0..59
- o_hour  out  5  hours 0..23
- o_running  out  1  1 while in RUN state

## Operation

- States: STOP (reset state), RUN, CLEAR.
- STOP: counts hold. i_run_stop=1 -> RUN. Else i_clear=1 -> CLEAR. Both asserted in the same cycle: i_run_stop wins, clear dropped.
- RUN: each cycle with i_tick_100hz=1 increments the cascade. i_run_stop=1 -> STOP. i_clear ignored in RUN.
- CLEAR: all four counts forced to 0 in this one cycle; unconditionally -> STOP next cycle; i_tick_100hz and i_run_stop ignored while in CLEAR.
- Cascade on a counted tick: msec+1; if msec==MSEC_MAX-1, msec->0 and sec+1; if sec==SEC_MAX-1 as well, sec->0 and min+1; likewise min->hour; hour==HOUR_MAX-1 with carry-in -> hour->0 (full wrap 23:59:59.99 -> 00:00:00.00, no overflow flag).
- Counter widths are $clog2 of each modulus; counts never exceed modulus-1 under any input sequence.
- o_running is registered, equal to (state==RUN).

## Timing

- All outputs registered; reset values: o_msec=0, o_sec=0, o_min=0, o_hour=0, o_running=0, state=STOP.
- Reset is synchronous and dominates every other input in the same cycle; reset mid-RUN zeroes counts and returns to STOP on the next edge.
- Tick counting uses the current state: a tick in cycle N while state==RUN updates counts visible at cycle N+1, even if i_run_stop is also asserted in cycle N (tick counted, then STOP).
- A tick in the cycle where STOP->RUN transition is requested is not counted (state still STOP).
- State transitions take effect one clk after the requesting pulse; o_running follows state with the same latency (pulse at N -> o_running changes at N+1).
- i_clear at cycle N in STOP -> state CLEAR at N+1, counts read 0 from N+2, state STOP at N+2.
- Carry cascade completes in a single cycle; all four outputs change on the same edge.
- Inputs assumed synchronous to clk; no internal synchronizers.

## Test plan

- Reset with rst=0 for 3 cycles while i_run_stop pulsed -> all counts 0, o_running=0 after release.
- Pulse i_run_stop, then 150 ticks -> o_running=1, o_sec=1, o_msec=50; pulse i_run_stop, 20 more ticks -> counts unchanged at 1.50, o_running=0.
- Preload via ticks to 00:00:59.99, one tick -> 00:01:00.00; at 23:59:59.99, one tick -> 00:00:00.00 all on one edge.
- Tick and i_run_stop asserted same cycle in RUN -> msec advances by 1 and o_running=0 next cycle; same coincidence in STOP -> no increment, o_running=1.
- i_clear pulsed in RUN at count 0.37 -> ignored, counting continues; stop, then i_clear -> counts 0 two cycles later, state STOP; i_clear and i_run_stop together in STOP -> RUN, counts not cleared.
- rst=0 asserted mid-RUN at 00:02:13.45 -> next edge all counts 0, o_running=0; subsequent ticks not counted until i_run_stop.
